// File: rtl/shared_buffer_multi_fifo_pkg.sv
// ============================================================================
// Module  : shared_buffer_multi_fifo_pkg
// Brief   : Width helpers and shared types for the shared-buffer multi-FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shared_buffer_multi_fifo_pkg;

    // Pool index width; a one-entry pool still needs a 1-bit index.
    function automatic int f_ptr_width(input int num_elems);
        return (num_elems > 1) ? $clog2(num_elems) : 1;
    endfunction

    function automatic int f_qid_width(input int num_queues);
        return (num_queues > 1) ? $clog2(num_queues) : 1;
    endfunction

    // Where a freshly allocated entry lands in its target queue.
    typedef enum logic [1:0] {
        LINK_NONE    = 2'd0,
        LINK_AS_HEAD = 2'd1,
        LINK_APPEND  = 2'd2
    } push_link_e;

endpackage

`default_nettype wire

// File: rtl/shared_buffer_multi_fifo_sb_free_list.sv
// ============================================================================
// Module  : sb_free_list
// Brief   : Free-list head/tail and the shared next-pointer RAM; one alloc and
//           one release per cycle plus one queue-link write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_free_list
    import shared_buffer_multi_fifo_pkg::*;
#(
    parameter int NUM_ELEMS = 8,
    parameter int PTR_WIDTH = f_ptr_width(NUM_ELEMS),
    parameter int CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_i,
    output logic [PTR_WIDTH-1:0] alloc_idx_o,
    input  logic                 release_i,
    input  logic [PTR_WIDTH-1:0] release_idx_i,
    input  logic                 link_we_i,
    input  logic [PTR_WIDTH-1:0] link_addr_i,
    input  logic [PTR_WIDTH-1:0] link_data_i,
    input  logic [PTR_WIDTH-1:0] rd_addr_i,
    output logic [PTR_WIDTH-1:0] rd_data_o
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    logic [PTR_WIDTH-1:0] next_q [NUM_ELEMS];
    logic [PTR_WIDTH-1:0] fhead_q, fhead_d;
    logic [PTR_WIDTH-1:0] ftail_q, ftail_d;
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                 w_fl_we;

    always_comb begin
        fhead_d = fhead_q;
        ftail_d = ftail_q;
        fcnt_d  = fcnt_q + CNT_WIDTH'(release_i) - CNT_WIDTH'(alloc_i);
        w_fl_we = 1'b0;
        if (alloc_i) begin
            fhead_d = next_q[fhead_q];
        end
        // If the list is (or is about to become) empty, the released entry
        // stands alone; otherwise it is chained behind the current tail.
        if (release_i) begin
            ftail_d = release_idx_i;
            if ((fcnt_q == '0) || (alloc_i && (fcnt_q == C_ONE))) begin
                fhead_d = release_idx_i;
            end else begin
                w_fl_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fhead_q <= '0;
            ftail_q <= PTR_WIDTH'(NUM_ELEMS - 1);
            fcnt_q  <= CNT_WIDTH'(NUM_ELEMS);
            for (int i = 0; i < NUM_ELEMS; i++) begin
                next_q[i] <= PTR_WIDTH'((i + 1) % NUM_ELEMS);
            end
        end else begin
            fhead_q <= fhead_d;
            ftail_q <= ftail_d;
            fcnt_q  <= fcnt_d;
            // Queue tails and the free tail are disjoint entries, so the two
            // writes never collide.
            if (link_we_i) begin
                next_q[link_addr_i] <= link_data_i;
            end
            if (w_fl_we) begin
                next_q[ftail_q] <= release_idx_i;
            end
        end
    end

    assign alloc_idx_o = fhead_q;
    assign rd_data_o   = next_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/shared_buffer_multi_fifo.sv
// ============================================================================
// Module  : shared_buffer_multi_fifo
// Brief   : NUM_QUEUES linked-list FIFOs sharing one NUM_ELEMS-entry pool.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_buffer_multi_fifo
    import shared_buffer_multi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ELEMS  = 8,
    parameter int NUM_QUEUES = 4,
    parameter int PTR_WIDTH  = f_ptr_width(NUM_ELEMS),
    parameter int QID_WIDTH  = f_qid_width(NUM_QUEUES),
    parameter int CNT_WIDTH  = PTR_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_valid_i,
    input  logic [QID_WIDTH-1:0]             push_qid_i,
    input  logic [DATA_WIDTH-1:0]            push_data_i,
    output logic                             push_ready_o,
    input  logic                             pop_valid_i,
    input  logic [QID_WIDTH-1:0]             pop_qid_i,
    output logic                             pop_ready_o,
    output logic [DATA_WIDTH-1:0]            pop_data_o,
    output logic [NUM_QUEUES-1:0]            empty_o,
    output logic                             full_o,
    output logic [CNT_WIDTH-1:0]             total_count_o,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]  q_count_o,
    output logic                             err_sticky_o
);

    localparam logic [CNT_WIDTH-1:0] C_FULL_CNT = CNT_WIDTH'(NUM_ELEMS);
    localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);
    localparam logic [QID_WIDTH:0]   C_NUM_Q    = (QID_WIDTH + 1)'(NUM_QUEUES);

    logic [PTR_WIDTH-1:0]  head_q [NUM_QUEUES];
    logic [PTR_WIDTH-1:0]  head_d [NUM_QUEUES];
    logic [PTR_WIDTH-1:0]  tail_q [NUM_QUEUES];
    logic [PTR_WIDTH-1:0]  tail_d [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]  qcnt_q [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]  qcnt_d [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_mem [NUM_ELEMS];

    logic                  w_push_qid_ok, w_pop_qid_ok;
    logic [QID_WIDTH-1:0]  w_push_q, w_pop_q;
    logic                  w_full, w_pop_ready;
    logic                  w_push_fire, w_pop_fire;
    logic [PTR_WIDTH-1:0]  w_alloc_idx, w_pop_head, w_pop_next;
    logic                  w_link_we;
    logic [PTR_WIDTH-1:0]  w_link_addr, w_link_data;
    push_link_e            w_push_kind;

    // Out-of-range qids are steered to queue 0 for indexing only; they never fire.
    assign w_push_qid_ok = ({1'b0, push_qid_i} < C_NUM_Q);
    assign w_pop_qid_ok  = ({1'b0, pop_qid_i} < C_NUM_Q);
    assign w_push_q      = w_push_qid_ok ? push_qid_i : '0;
    assign w_pop_q       = w_pop_qid_ok ? pop_qid_i : '0;

    assign w_full      = (total_q == C_FULL_CNT);
    assign w_pop_ready = w_pop_qid_ok && (qcnt_q[w_pop_q] != '0);
    assign w_push_fire = push_valid_i && !w_full && w_push_qid_ok;
    assign w_pop_fire  = pop_valid_i && w_pop_ready;
    assign w_pop_head  = head_q[w_pop_q];

    sb_free_list #(
        .NUM_ELEMS (NUM_ELEMS),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (w_push_fire),
        .alloc_idx_o   (w_alloc_idx),
        .release_i     (w_pop_fire),
        .release_idx_i (w_pop_head),
        .link_we_i     (w_link_we),
        .link_addr_i   (w_link_addr),
        .link_data_i   (w_link_data),
        .rd_addr_i     (w_pop_head),
        .rd_data_o     (w_pop_next)
    );

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        qcnt_d      = qcnt_q;
        err_d       = err_q;
        w_link_we   = 1'b0;
        w_link_addr = '0;
        w_link_data = '0;
        w_push_kind = LINK_NONE;

        if (w_pop_fire) begin
            head_d[w_pop_q] = w_pop_next;
            qcnt_d[w_pop_q] = qcnt_q[w_pop_q] - C_ONE;
        end

        // Emptiness is judged after any same-cycle pop of the same queue.
        if (w_push_fire) begin
            if ((qcnt_q[w_push_q] == '0) ||
                (w_pop_fire && (w_pop_q == w_push_q) && (qcnt_q[w_push_q] == C_ONE))) begin
                w_push_kind = LINK_AS_HEAD;
            end else begin
                w_push_kind = LINK_APPEND;
            end
        end

        case (w_push_kind)
            LINK_AS_HEAD: begin
                head_d[w_push_q] = w_alloc_idx;
                tail_d[w_push_q] = w_alloc_idx;
                qcnt_d[w_push_q] = qcnt_d[w_push_q] + C_ONE;
            end
            LINK_APPEND: begin
                w_link_we        = 1'b1;
                w_link_addr      = tail_q[w_push_q];
                w_link_data      = w_alloc_idx;
                tail_d[w_push_q] = w_alloc_idx;
                qcnt_d[w_push_q] = qcnt_d[w_push_q] + C_ONE;
            end
            default: ;
        endcase

        total_d = total_q + CNT_WIDTH'(w_push_fire) - CNT_WIDTH'(w_pop_fire);

        if ((push_valid_i && (w_full || !w_push_qid_ok)) || (pop_valid_i && !w_pop_ready)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
                qcnt_q[q] <= '0;
            end
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            qcnt_q  <= qcnt_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            data_mem[w_alloc_idx] <= push_data_i;
        end
    end

    generate
        for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_qstat
            assign empty_o[q]                          = (qcnt_q[q] == '0);
            assign q_count_o[q*CNT_WIDTH +: CNT_WIDTH] = qcnt_q[q];
        end
    endgenerate

    assign push_ready_o  = !w_full;
    assign pop_ready_o   = w_pop_ready;
    assign pop_data_o    = data_mem[w_pop_head];
    assign full_o        = w_full;
    assign total_count_o = total_q;
    assign err_sticky_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_buffer_multi_fifo.sv
// ============================================================================
// Module  : tb_shared_buffer_multi_fifo
// Brief   : Directed scenarios plus a scoreboarded random run for the
//           shared-buffer multi-FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_buffer_multi_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_valid = 1'b0;
    logic [1:0]  push_qid = '0;
    logic [7:0]  push_data = '0;
    logic        push_ready;
    logic        pop_valid = 1'b0;
    logic [1:0]  pop_qid = '0;
    logic        pop_ready;
    logic [7:0]  pop_data;
    logic [3:0]  empty;
    logic        full;
    logic [3:0]  total_count;
    logic [15:0] q_count;
    logic        err_sticky;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq [4][$];
    int         mtotal;

    always #5 clk = ~clk;

    shared_buffer_multi_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid_i  (push_valid),
        .push_qid_i    (push_qid),
        .push_data_i   (push_data),
        .push_ready_o  (push_ready),
        .pop_valid_i   (pop_valid),
        .pop_qid_i     (pop_qid),
        .pop_ready_o   (pop_ready),
        .pop_data_o    (pop_data),
        .empty_o       (empty),
        .full_o        (full),
        .total_count_o (total_count),
        .q_count_o     (q_count),
        .err_sticky_o  (err_sticky)
    );

    function automatic logic [3:0] qc(input int q);
        return q_count[q*4 +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_push(input logic [1:0] q, input logic [7:0] d);
        push_valid = 1'b1;
        push_qid   = q;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic do_pop(input logic [1:0] q, output logic [7:0] d, output logic rdy);
        pop_valid = 1'b1;
        pop_qid   = q;
        #1;
        d   = pop_data;
        rdy = pop_ready;
        tick();
        pop_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        pop_qid = 2'd0;
        #1;
        checks++; if (total_count !== 4'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_count); end
        checks++; if (empty !== 4'hF) begin failures++; $display("FAIL reset_empty got=%h exp=f", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_sticky); end
        checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
        checks++; if (pop_ready !== 1'b0) begin failures++; $display("FAIL reset_pop_ready got=%b exp=0", pop_ready); end
        checks++; if (q_count !== 16'h0) begin failures++; $display("FAIL reset_qcount got=%h exp=0", q_count); end
    endtask

    task automatic test_basic_order();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] d;
        logic       r;
        for (int i = 0; i < 3; i++) do_push(2'd0, exp_d[i]);
        checks++; if (qc(0) !== 4'd3) begin failures++; $display("FAIL basic_qcount0 got=%0d exp=3", qc(0)); end
        checks++; if (total_count !== 4'd3) begin failures++; $display("FAIL basic_total got=%0d exp=3", total_count); end
        for (int i = 0; i < 3; i++) begin
            do_pop(2'd0, d, r);
            checks++; if (r !== 1'b1 || d !== exp_d[i]) begin failures++; $display("FAIL basic_pop%0d got=%h/%b exp=%h/1", i, d, r, exp_d[i]); end
        end
        checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL basic_empty0 got=%b exp=1", empty[0]); end
    endtask

    task automatic test_interleave();
        logic [7:0] d;
        logic       r;
        logic [7:0] exp_q1 [2] = '{8'hB0, 8'hB1};
        logic [7:0] exp_q0 [2] = '{8'hA0, 8'hA1};
        do_push(2'd0, 8'hA0);
        do_push(2'd1, 8'hB0);
        do_push(2'd0, 8'hA1);
        do_push(2'd1, 8'hB1);
        checks++; if (qc(0) !== 4'd2 || qc(1) !== 4'd2) begin failures++; $display("FAIL inter_qcount got=%0d,%0d exp=2,2", qc(0), qc(1)); end
        for (int i = 0; i < 2; i++) begin
            do_pop(2'd1, d, r);
            checks++; if (r !== 1'b1 || d !== exp_q1[i]) begin failures++; $display("FAIL inter_q1_pop%0d got=%h exp=%h", i, d, exp_q1[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            do_pop(2'd0, d, r);
            checks++; if (r !== 1'b1 || d !== exp_q0[i]) begin failures++; $display("FAIL inter_q0_pop%0d got=%h exp=%h", i, d, exp_q0[i]); end
        end
        checks++; if (empty !== 4'hF || total_count !== 4'd0) begin failures++; $display("FAIL inter_drained got=%h/%0d exp=f/0", empty, total_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) do_push(2'(i % 4), 8'(8'h40 + i));
        checks++; if (full !== 1'b1 || push_ready !== 1'b0) begin failures++; $display("FAIL full_flags got=%b/%b exp=1/0", full, push_ready); end
        checks++; if (total_count !== 4'd8) begin failures++; $display("FAIL full_total got=%0d exp=8", total_count); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL full_err_before got=%b exp=0", err_sticky); end
        do_push(2'd0, 8'hEE);
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL full_err_after got=%b exp=1", err_sticky); end
        checks++; if (total_count !== 4'd8 || qc(0) !== 4'd2) begin failures++; $display("FAIL full_unchanged got=%0d/%0d exp=8/2", total_count, qc(0)); end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp_t [4][2] = '{'{8'h40, 8'h44}, '{8'h41, 8'h45}, '{8'h46, 8'h99}, '{8'h43, 8'h47}};
        logic [7:0] d;
        logic       r;
        push_valid = 1'b1; push_qid = 2'd2; push_data = 8'h99;
        pop_valid  = 1'b1; pop_qid  = 2'd2;
        #1;
        checks++; if (pop_data !== 8'h42) begin failures++; $display("FAIL fpp_pop_data got=%h exp=42", pop_data); end
        tick();
        push_valid = 1'b0; pop_valid = 1'b0;
        checks++; if (total_count !== 4'd7 || qc(2) !== 4'd1) begin failures++; $display("FAIL fpp_blocked got=%0d/%0d exp=7/1", total_count, qc(2)); end
        do_push(2'd2, 8'h99);
        checks++; if (total_count !== 4'd8 || qc(2) !== 4'd2) begin failures++; $display("FAIL fpp_accepted got=%0d/%0d exp=8/2", total_count, qc(2)); end
        for (int q = 0; q < 4; q++) begin
            for (int i = 0; i < 2; i++) begin
                do_pop(2'(q), d, r);
                checks++; if (r !== 1'b1 || d !== exp_t[q][i]) begin failures++; $display("FAIL fpp_drain_q%0d_%0d got=%h exp=%h", q, i, d, exp_t[q][i]); end
            end
        end
        checks++; if (empty !== 4'hF || total_count !== 4'd0) begin failures++; $display("FAIL fpp_drained got=%h/%0d exp=f/0", empty, total_count); end
    endtask

    task automatic test_same_queue_single();
        logic [7:0] d;
        logic       r;
        apply_reset();
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL sq_err_cleared got=%b exp=0", err_sticky); end
        do_push(2'd3, 8'h5A);
        push_valid = 1'b1; push_qid = 2'd3; push_data = 8'hA5;
        pop_valid  = 1'b1; pop_qid  = 2'd3;
        #1;
        checks++; if (pop_data !== 8'h5A) begin failures++; $display("FAIL sq_pop_data got=%h exp=5a", pop_data); end
        tick();
        push_valid = 1'b0; pop_valid = 1'b0;
        checks++; if (qc(3) !== 4'd1 || total_count !== 4'd1) begin failures++; $display("FAIL sq_count got=%0d/%0d exp=1/1", qc(3), total_count); end
        do_pop(2'd3, d, r);
        checks++; if (r !== 1'b1 || d !== 8'hA5) begin failures++; $display("FAIL sq_second_pop got=%h exp=a5", d); end
        do_pop(2'd3, d, r);
        checks++; if (r !== 1'b0) begin failures++; $display("FAIL sq_empty_ready got=%b exp=0", r); end
        checks++; if (err_sticky !== 1'b1 || total_count !== 4'd0) begin failures++; $display("FAIL sq_empty_pop_err got=%b/%0d exp=1/0", err_sticky, total_count); end
    endtask

    task automatic test_random();
        int  pq, uq;
        bit  pv, ov, exp_full, pop_ok;
        logic [7:0] pd;
        apply_reset();
        for (int q = 0; q < 4; q++) mq[q].delete();
        mtotal = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pv = ($urandom_range(0, 3) < ((cyc < 5000) ? 3 : 2));
            ov = ($urandom_range(0, 3) < ((cyc < 5000) ? 2 : 3));
            uq = $urandom_range(0, 3);
            pq = $urandom_range(0, 3);
            pd = 8'($urandom);
            push_valid = pv; push_qid = 2'(uq); push_data = pd;
            pop_valid  = ov; pop_qid  = 2'(pq);
            if (cyc == 5000) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                push_valid = 1'b0; pop_valid = 1'b0;
                for (int q = 0; q < 4; q++) mq[q].delete();
                mtotal = 0;
                checks++; if (empty !== 4'hF || total_count !== 4'd0) begin failures++; $display("FAIL rand_midrst got=%h/%0d exp=f/0", empty, total_count); end
                continue;
            end
            #1;
            exp_full = (mtotal == 8);
            pop_ok   = (mq[pq].size() != 0);
            checks++; if (pop_ready !== pop_ok) begin failures++; $display("FAIL rand_pop_ready cyc=%0d got=%b exp=%b", cyc, pop_ready, pop_ok); end
            if (ov && pop_ok) begin
                checks++; if (pop_data !== mq[pq][0]) begin failures++; $display("FAIL rand_pop_data cyc=%0d got=%h exp=%h", cyc, pop_data, mq[pq][0]); end
            end
            checks++; if (total_count !== 4'(mtotal) || push_ready !== !exp_full) begin failures++; $display("FAIL rand_total cyc=%0d got=%0d/%b exp=%0d/%b", cyc, total_count, push_ready, mtotal, !exp_full); end
            checks++; if (qc(cyc % 4) !== 4'(mq[cyc % 4].size())) begin failures++; $display("FAIL rand_qcount cyc=%0d q=%0d got=%0d exp=%0d", cyc, cyc % 4, qc(cyc % 4), mq[cyc % 4].size()); end
            if (ov && pop_ok) begin
                void'(mq[pq].pop_front());
                mtotal--;
            end
            if (pv && !exp_full) begin
                mq[uq].push_back(pd);
                mtotal++;
            end
            #1;
            tick();
        end
        push_valid = 1'b0;
        pop_valid  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_interleave();
        test_full();
        test_full_pop_push();
        test_same_queue_single();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
